range_norm_pipe: RTL and testbench

RANGE_NORM_PIPE -- requirements
Module: range_norm_pipe

---
 rtl/range_norm_pipe.sv | 225 ++++++++++++++++++++++
 tb/tb_range_norm_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : range_norm_pipe
//  Purpose  : Range-coder update stage. Scales the internally held range R by
//             the CDF operands, selects the new sub-range (boolean or
//             multi-symbol path), renormalises it with a leading-zero shift
//             and counts the shift bits. One registered output beat per
//             accepted symbol, with a valid/ready handshake on both sides.
//  Ports    : clk, reset (sync, active-high), start (re-init R / bit_count)
//             in_valid/in_ready, UU, VV, lut_u, lut_v, COMP_mux_1, symbol,
//             bool                                      -- input beat
//             out_valid/out_ready, u, v_bool, initial_range, out_range, out_d,
//             bool_symbol, COMP_mux_1_out               -- output beat
//             bit_count (accumulated shifts), err (sticky zero-range flag)
//  Config   : RANGE_NORM_ZERO_CHECK_EN -- when defined, a zero new range sets
//             err and leaves R / bit_count untouched. When undefined, err is
//             tied low and a zero range normalises like any other value.
//  Revision : 1.0 -- initial release
// ============================================================================
module range_norm_pipe #(
    parameter int RANGE_WIDTH  = 16,
    parameter int D_SIZE       = 5,
    parameter int SYMBOL_WIDTH = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RANGE_WIDTH-1:0]  UU,
    input  logic [RANGE_WIDTH-1:0]  VV,
    input  logic [RANGE_WIDTH-1:0]  lut_u,
    input  logic [RANGE_WIDTH-1:0]  lut_v,
    input  logic                    COMP_mux_1,
    input  logic [SYMBOL_WIDTH-1:0] symbol,
    input  logic                    bool,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RANGE_WIDTH:0]    u,
    output logic [RANGE_WIDTH:0]    v_bool,
    output logic [RANGE_WIDTH-1:0]  initial_range,
    output logic [RANGE_WIDTH-1:0]  out_range,
    output logic [D_SIZE-1:0]       out_d,
    output logic [1:0]              bool_symbol,
    output logic                    COMP_mux_1_out,
    output logic [CNT_WIDTH-1:0]    bit_count,
    output logic                    err
);

    localparam logic [RANGE_WIDTH-1:0] c_range_init = RANGE_WIDTH'(1) << (RANGE_WIDTH - 1);
    localparam logic [RANGE_WIDTH:0]   c_bool_ofs   = (RANGE_WIDTH + 1)'(4);

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [RANGE_WIDTH-1:0] r_range;
    logic [CNT_WIDTH-1:0]   r_bit_count;
    logic                   r_out_valid;
    logic [RANGE_WIDTH:0]   r_u;
    logic [RANGE_WIDTH:0]   r_v_bool;
    logic [RANGE_WIDTH-1:0] r_initial_range;
    logic [RANGE_WIDTH-1:0] r_out_range;
    logic [D_SIZE-1:0]      r_out_d;
    logic [1:0]             r_bool_symbol;
    logic                   r_comp_mux_1_out;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    logic                   w_accept;
    logic [7:0]             w_rr;
    logic [RANGE_WIDTH+1:0] w_rr_x;
    logic [RANGE_WIDTH+1:0] w_uu_x;
    logic [RANGE_WIDTH+1:0] w_vv_x;
    logic [RANGE_WIDTH:0]   w_uhalf;
    logic [RANGE_WIDTH:0]   w_vhalf;
    logic [RANGE_WIDTH:0]   w_u;
    logic [RANGE_WIDTH:0]   w_v;
    logic [RANGE_WIDTH:0]   w_v_bool;
    logic [RANGE_WIDTH-1:0] w_new_range;
    logic [D_SIZE-1:0]      w_d;
    logic [RANGE_WIDTH-1:0] w_norm;
    logic                   w_zero;

    assign in_ready = (!r_out_valid || out_ready) && !start;
    assign w_accept = in_valid && in_ready;

    // Top 8 bits of the range act as the scale factor.
    assign w_rr   = r_range[RANGE_WIDTH-1 -: 8];

    // Products are formed two bits wider than the result so that after the
    // >>1 every one of the RANGE_WIDTH+1 result bits is exact.
    assign w_rr_x = {{(RANGE_WIDTH - 6){1'b0}}, w_rr};
    assign w_uu_x = {2'b00, UU};
    assign w_vv_x = {2'b00, VV};

    assign w_uhalf  = (RANGE_WIDTH + 1)'((w_rr_x * w_uu_x) >> 1);
    assign w_vhalf  = (RANGE_WIDTH + 1)'((w_rr_x * w_vv_x) >> 1);
    assign w_u      = w_uhalf + {1'b0, lut_u};
    assign w_v      = w_vhalf + {1'b0, lut_v};
    assign w_v_bool = w_vhalf + c_bool_ofs;

    always_comb begin
        w_new_range = '0;
        if (bool) begin
            if (symbol[0]) begin
                w_new_range = w_v_bool[RANGE_WIDTH-1:0];
            end else begin
                w_new_range = r_range - w_v_bool[RANGE_WIDTH-1:0];
            end
        end else begin
            if (COMP_mux_1) begin
                w_new_range = w_u[RANGE_WIDTH-1:0] - w_v[RANGE_WIDTH-1:0];
            end else begin
                w_new_range = r_range - w_v[RANGE_WIDTH-1:0];
            end
        end
    end

    // Leading-zero count; an all-zero range yields RANGE_WIDTH.
    always_comb begin
        logic found;
        w_d   = D_SIZE'(RANGE_WIDTH);
        found = 1'b0;
        for (int i = RANGE_WIDTH - 1; i >= 0; i--) begin
            if (!found && w_new_range[i]) begin
                w_d   = D_SIZE'(RANGE_WIDTH - 1 - i);
                found = 1'b1;
            end
        end
    end

    // A shift by RANGE_WIDTH clears the value, so the zero case needs no
    // special handling here.
    assign w_norm = w_new_range << w_d;
    assign w_zero = (w_new_range == '0);

    // ------------------------------------------------------------------------
    // Range state, bit counter and optional zero-range error
    // ------------------------------------------------------------------------
`ifdef RANGE_NORM_ZERO_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_range     <= c_range_init;
            r_bit_count <= '0;
            r_err       <= 1'b0;
        end else if (start) begin
            r_range     <= c_range_init;
            r_bit_count <= '0;
        end else if (w_accept) begin
            if (w_zero) begin
                r_err <= 1'b1;
            end else begin
                r_range     <= w_norm;
                r_bit_count <= r_bit_count + CNT_WIDTH'(w_d);
            end
        end
    end

    assign err = r_err;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_range     <= c_range_init;
            r_bit_count <= '0;
        end else if (start) begin
            r_range     <= c_range_init;
            r_bit_count <= '0;
        end else if (w_accept) begin
            r_range     <= w_norm;
            r_bit_count <= r_bit_count + CNT_WIDTH'(w_d);
        end
    end

    assign err = 1'b0;

    // Zero detection only matters for the error path.
    logic w_zero_unused;
    assign w_zero_unused = w_zero;
`endif

    // ------------------------------------------------------------------------
    // Output beat register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_u              <= '0;
            r_v_bool         <= '0;
            r_initial_range  <= '0;
            r_out_range      <= '0;
            r_out_d          <= '0;
            r_bool_symbol    <= '0;
            r_comp_mux_1_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid      <= 1'b1;
                r_u              <= w_u;
                r_v_bool         <= w_v_bool;
                r_initial_range  <= r_range;
                r_out_range      <= w_norm;
                r_out_d          <= w_d;
                r_bool_symbol    <= {bool, symbol[0]};
                r_comp_mux_1_out <= COMP_mux_1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid      = r_out_valid;
    assign u              = r_u;
    assign v_bool         = r_v_bool;
    assign initial_range  = r_initial_range;
    assign out_range      = r_out_range;
    assign out_d          = r_out_d;
    assign bool_symbol    = r_bool_symbol;
    assign COMP_mux_1_out = r_comp_mux_1_out;
    assign bit_count      = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_range_norm_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_range_norm_pipe
//  Purpose  : Directed-vector bench for range_norm_pipe. Stimulus pushes the
//             hand-computed expected beat into a queue; a monitor pops and
//             compares whenever the DUT hands over an output beat.
//  Revision : 1.0 -- initial release
// ============================================================================
module tb_range_norm_pipe;

    typedef struct {
        logic [16:0] u;
        logic [16:0] v_bool;
        logic [15:0] init;
        logic [15:0] rng;
        logic [4:0]  d;
        logic [1:0]  bs;
        logic        cmo;
        logic [31:0] bc;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] UU = '0;
    logic [15:0] VV = '0;
    logic [15:0] lut_u = '0;
    logic [15:0] lut_v = '0;
    logic        COMP_mux_1 = 1'b0;
    logic [3:0]  symbol = '0;
    logic        bool = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [16:0] u;
    logic [16:0] v_bool;
    logic [15:0] initial_range;
    logic [15:0] out_range;
    logic [4:0]  out_d;
    logic [1:0]  bool_symbol;
    logic        COMP_mux_1_out;
    logic [31:0] bit_count;
    logic        err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    range_norm_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .UU             (UU),
        .VV             (VV),
        .lut_u          (lut_u),
        .lut_v          (lut_v),
        .COMP_mux_1     (COMP_mux_1),
        .symbol         (symbol),
        .bool           (bool),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .u              (u),
        .v_bool         (v_bool),
        .initial_range  (initial_range),
        .out_range      (out_range),
        .out_d          (out_d),
        .bool_symbol    (bool_symbol),
        .COMP_mux_1_out (COMP_mux_1_out),
        .bit_count      (bit_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: a beat is handed over at the next rising edge when both
    // out_valid and out_ready are high.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got out_range 0x%0h expected no beat", out_range);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("u",             64'(u),              64'(e.u));
                chk("v_bool",        64'(v_bool),         64'(e.v_bool));
                chk("initial_range", 64'(initial_range),  64'(e.init));
                chk("out_range",     64'(out_range),      64'(e.rng));
                chk("out_d",         64'(out_d),          64'(e.d));
                chk("bool_symbol",   64'(bool_symbol),    64'(e.bs));
                chk("comp_mux_out",  64'(COMP_mux_1_out), 64'(e.cmo));
                chk("bit_count",     64'(bit_count),      64'(e.bc));
                chk("err",           64'(err),            64'(e.err));
            end
        end
    end

    task automatic drive(input logic b, input logic [3:0] sym, input logic mux,
                         input logic [15:0] uu_i, input logic [15:0] vv_i,
                         input logic [15:0] lu, input logic [15:0] lv);
        bool       = b;
        symbol     = sym;
        COMP_mux_1 = mux;
        UU         = uu_i;
        VV         = vv_i;
        lut_u      = lu;
        lut_v      = lv;
        in_valid   = 1'b1;
    endtask

    // Drive a beat, wait (bounded) for acceptance, and register its expectation.
    task automatic send(input logic b, input logic [3:0] sym, input logic mux,
                        input logic [15:0] uu_i, input logic [15:0] vv_i,
                        input logic [15:0] lu, input logic [15:0] lv,
                        input exp_t e, input bit push);
        int n;
        drive(b, sym, mux, uu_i, vv_i, lu, lv);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else if (push) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    exp_t e;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_bit_count", 64'(bit_count), 64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_out_range", 64'(out_range), 64'd0);
        chk("rst_u",         64'(u),         64'd0);
        @(posedge clk);
        #1;

        // Boolean path, symbol=1: new range = v_bool = 0x4004 -> 0x8008, d=1
        e = '{17'h00000, 17'h04004, 16'h8000, 16'h8008, 5'd1, 2'b11, 1'b0, 32'd1, 1'b0};
        send(1'b1, 4'h1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, e, 1'b1);

        // start with in_valid high: no accept, R and bit_count re-initialised
        drive(1'b1, 4'h1, 1'b0, 16'h1234, 16'h0100, 16'h0000, 16'h0000);
        start = 1'b1;
        @(negedge clk);
        chk("start_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("start_bit_count", 64'(bit_count), 64'd0);
        chk("start_no_beat",   64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Boolean path, symbol=0: 0x8000-0x4004 = 0x3FFC -> 0xFFF0, d=2
        e = '{17'h00000, 17'h04004, 16'h8000, 16'hFFF0, 5'd2, 2'b10, 1'b0, 32'd2, 1'b0};
        send(1'b1, 4'h0, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, e, 1'b1);

        start = 1'b1;
        idle(1);
        start = 1'b0;

        // Multi-symbol path twice back to back: 0x6008-0x4004 = 0x2004 -> 0x8010
        e = '{17'h06008, 17'h04004, 16'h8000, 16'h8010, 5'd2, 2'b00, 1'b1, 32'd2, 1'b0};
        send(1'b0, 4'h0, 1'b1, 16'h0180, 16'h0100, 16'h0008, 16'h0004, e, 1'b1);
        e = '{17'h06008, 17'h04004, 16'h8010, 16'h8010, 5'd2, 2'b00, 1'b1, 32'd4, 1'b0};
        send(1'b0, 4'h0, 1'b1, 16'h0180, 16'h0100, 16'h0008, 16'h0004, e, 1'b1);

        // R - v path: 0x8010-0x4004 = 0x400C -> 0x8018, d=1
        e = '{17'h04000, 17'h04004, 16'h8010, 16'h8018, 5'd1, 2'b01, 1'b0, 32'd5, 1'b0};
        send(1'b0, 4'h1, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0004, e, 1'b1);
        idle(1);

        // Backpressure: RR=0x80, VV=0x80 -> v_bool 0x2004 -> 0x8010, d=2
        out_ready = 1'b0;
        e = '{17'h00000, 17'h02004, 16'h8018, 16'h8010, 5'd2, 2'b11, 1'b0, 32'd7, 1'b0};
        send(1'b1, 4'h1, 1'b0, 16'h0000, 16'h0080, 16'h0000, 16'h0000, e, 1'b1);
        drive(1'b0, 4'h0, 1'b1, 16'h0180, 16'h0100, 16'h0008, 16'h0004);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  64'(in_ready),      64'd0);
            chk("bp_out_valid", 64'(out_valid),     64'd1);
            chk("bp_out_range", 64'(out_range),     64'h8010);
            chk("bp_init",      64'(initial_range), 64'h8018);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        e = '{17'h06008, 17'h04004, 16'h8010, 16'h8010, 5'd2, 2'b00, 1'b1, 32'd9, 1'b0};
        send(1'b0, 4'h0, 1'b1, 16'h0180, 16'h0100, 16'h0008, 16'h0004, e, 1'b1);
        idle(1);

        // Reset with a pending beat discards it
        out_ready = 1'b0;
        send(1'b1, 4'h1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, e, 1'b0);
        @(negedge clk);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_bit_count", 64'(bit_count), 64'd0);
        chk("post_rst_out_range", 64'(out_range), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Zero range: u == v, then a boolean beat to observe the resulting R
`ifdef RANGE_NORM_ZERO_CHECK_EN
        e = '{17'h04004, 17'h04004, 16'h8000, 16'h0000, 5'd16, 2'b00, 1'b1, 32'd0, 1'b1};
        send(1'b0, 4'h0, 1'b1, 16'h0100, 16'h0100, 16'h0004, 16'h0004, e, 1'b1);
        e = '{17'h00000, 17'h04004, 16'h8000, 16'h8008, 5'd1, 2'b11, 1'b0, 32'd1, 1'b1};
        send(1'b1, 4'h1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, e, 1'b1);
`else
        e = '{17'h04004, 17'h04004, 16'h8000, 16'h0000, 5'd16, 2'b00, 1'b1, 32'd16, 1'b0};
        send(1'b0, 4'h0, 1'b1, 16'h0100, 16'h0100, 16'h0004, 16'h0004, e, 1'b1);
        // R = 0: v_bool = 4 -> 0x8000 after a 13-bit shift
        e = '{17'h00000, 17'h00004, 16'h0000, 16'h8000, 5'd13, 2'b11, 1'b0, 32'd29, 1'b0};
        send(1'b1, 4'h1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 16'h0000, e, 1'b1);
`endif
        idle(3);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
